// File: rtl/fetch_addr_sequencer_if.sv
// Instruction memory bus between the fetch address sequencer and the memory.
//   req    : request, held with addr until gnt (master -> slave)
//   addr   : word-aligned fetch address          (master -> slave)
//   gnt    : request accepted this cycle         (slave -> master)
//   rvalid : response data valid, in order       (slave -> master)
//   rdata  : response word                       (slave -> master)
interface fetch_addr_sequencer_if #(
  parameter int ADDR_W = 32
) ();
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_addr_sequencer.sv
// Fetch address sequencer: produces the instruction fetch address stream,
// drives the instruction bus, buffers returned words for decode, applies
// redirects and drops responses that belong to the pre-redirect stream.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_i                fetch enable
//   redirect_i           one-cycle redirect strobe, target on redirect_addr_i
//   instr                instruction bus (master side)
//   fetch_valid_o/ready  word handshake towards decode
//   fetch_rdata_o        buffered word
//   fetch_addr_o         PC of first useful parcel of the word
//   protocol_err_o       sticky: response seen with nothing outstanding
module fetch_addr_sequencer #(
  parameter int                ADDR_W        = 32,
  parameter logic [ADDR_W-1:0] BOOT_ADDR     = 32'h0000_0080,
  parameter int                DEPTH         = 2,
  parameter bit                COMPRESSED_EN = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  redirect_i,
  input  logic [ADDR_W-1:0]     redirect_addr_i,
  fetch_addr_sequencer_if.master instr,
  output logic                  fetch_valid_o,
  input  logic                  fetch_ready_i,
  output logic [31:0]           fetch_rdata_o,
  output logic [ADDR_W-1:0]     fetch_addr_o,
  output logic                  protocol_err_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, RUN} state_e;

  function automatic logic [ADDR_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  function automatic logic [ADDR_W-1:0] pc_of(input logic [ADDR_W-1:0] a);
    if (COMPRESSED_EN) return {a[ADDR_W-1:1], 1'b0};
    return word_of(a);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  state_e             state_q, state_n;
  logic               req_q, req_n;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_n;
  logic [ADDR_W-1:0]  fetch_addr_q, fetch_addr_n;
  logic [ADDR_W-1:0]  next_pc_q, next_pc_n;
  logic [CNT_W-1:0]   out_q, out_n;
  logic [CNT_W-1:0]   discard_q, discard_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_n;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_n;
  logic               err_q, err_n;

  logic [31:0]        data_mem [DEPTH];
  logic [ADDR_W-1:0]  pc_mem   [DEPTH];

  logic               granted, rvalid_ok, drop, push, pop, hold, issue, credit;
  logic [ADDR_W-1:0]  target_word;
  logic [CNT_W:0]     total_n;

  // Next-state computation. A request waiting for its grant (hold) is never
  // retracted or re-addressed; a redirect only retargets the following one.
  always_comb begin
    granted     = req_q & instr.gnt;
    rvalid_ok   = instr.rvalid & (out_q != '0);
    drop        = rvalid_ok & (discard_q != '0);
    push        = rvalid_ok & ~drop & ~redirect_i;
    pop         = (cnt_q != '0) & fetch_ready_i & ~redirect_i;
    hold        = req_q & ~instr.gnt;
    target_word = redirect_i ? word_of(redirect_addr_i) : fetch_addr_q;

    out_n = out_q;
    if (granted && !rvalid_ok)      out_n = out_q + CNT_W'(1);
    else if (!granted && rvalid_ok) out_n = out_q - CNT_W'(1);

    cnt_n = cnt_q;
    if (redirect_i)         cnt_n = '0;
    else if (push && !pop)  cnt_n = cnt_q + CNT_W'(1);
    else if (!push && pop)  cnt_n = cnt_q - CNT_W'(1);

    // Everything still in flight at a redirect is stale, including a
    // request that has not been granted yet.
    discard_n = drop ? discard_q - CNT_W'(1) : discard_q;
    if (redirect_i) discard_n = out_n + CNT_W'(hold);

    state_n = state_q;
    case (state_q)
      IDLE: if (req_i) state_n = RUN;
      RUN:  if (!req_i && !hold) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Credit covers words in flight plus words buffered, so a granted
    // request always has a FIFO slot waiting for its response.
    total_n = {1'b0, out_n} + {1'b0, cnt_n};
    credit  = total_n < (CNT_W + 1)'(DEPTH);
    issue   = ~hold & (state_n == RUN) & req_i & credit;

    req_n        = hold | issue;
    req_addr_n   = issue ? target_word : req_addr_q;
    fetch_addr_n = issue ? target_word + ADDR_W'(4) : target_word;

    next_pc_n = next_pc_q;
    if (redirect_i) next_pc_n = pc_of(redirect_addr_i);
    else if (push)  next_pc_n = word_of(next_pc_q) + ADDR_W'(4);

    rd_ptr_n = redirect_i ? '0 : (pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q);
    wr_ptr_n = redirect_i ? '0 : (push ? ptr_inc(wr_ptr_q) : wr_ptr_q);

    err_n = err_q | (instr.rvalid & (out_q == '0));
  end

  // Control state and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      req_addr_q   <= word_of(BOOT_ADDR);
      fetch_addr_q <= word_of(BOOT_ADDR);
      next_pc_q    <= pc_of(BOOT_ADDR);
      out_q        <= '0;
      discard_q    <= '0;
      cnt_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_n;
      req_q        <= req_n;
      req_addr_q   <= req_addr_n;
      fetch_addr_q <= fetch_addr_n;
      next_pc_q    <= next_pc_n;
      out_q        <= out_n;
      discard_q    <= discard_n;
      cnt_q        <= cnt_n;
      rd_ptr_q     <= rd_ptr_n;
      wr_ptr_q     <= wr_ptr_n;
      err_q        <= err_n;
    end
  end

  // Word buffer storage; occupancy is tracked by cnt_q so no reset needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem[wr_ptr_q] <= instr.rdata;
      pc_mem[wr_ptr_q]   <= next_pc_q;
    end
  end

  assign instr.req      = req_q;
  assign instr.addr     = req_addr_q;
  assign fetch_valid_o  = (cnt_q != '0);
  assign fetch_rdata_o  = data_mem[rd_ptr_q];
  assign fetch_addr_o   = (cnt_q != '0) ? pc_mem[rd_ptr_q] : next_pc_q;
  assign protocol_err_o = err_q;

endmodule
